// File: rtl/iterative_multdiv_unit.sv
// Multi-cycle signed/unsigned multiply (radix-2 shift-add) and divide (restoring)
// for the execute stage; fixed latency of WIDTH+2 cycles, divide-by-zero after 2.
module iterative_multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_signed,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] op_reg;
    logic [CW-1:0]    cnt_reg;
    logic             is_div_reg;
    logic             signed_reg;
    logic             neg_a_reg;
    logic             neg_b_reg;
    logic             min_ovf_reg;
    logic             exc_reg;

    logic             start;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] dividend_raw;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;
    logic             fix_exc;

    always_comb begin
        start   = ctrl_MULT | ctrl_DIV;
        a_neg   = ctrl_signed & data_operandA[WIDTH-1];
        b_neg   = ctrl_signed & data_operandB[WIDTH-1];
        a_mag   = a_neg ? -data_operandA : data_operandA;
        b_mag   = b_neg ? -data_operandB : data_operandB;

        // hi accumulates the partial product; lo shifts the multiplier out and product bits in
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, op_reg} : '0);

        // remainder < divisor, so a successful trial subtraction always fits in WIDTH bits
        div_shift = {hi_reg, lo_reg[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, op_reg};
        div_diff  = div_shift[WIDTH-1:0] - op_reg;

        prod         = {hi_reg, lo_reg};
        prod_fix     = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
        dividend_raw = neg_a_reg ? -lo_reg : lo_reg;

        if (is_div_reg) begin
            fix_lo  = (neg_a_reg ^ neg_b_reg) ? -lo_reg : lo_reg;
            fix_hi  = neg_a_reg ? -hi_reg : hi_reg;
            fix_exc = min_ovf_reg;
        end else begin
            fix_lo  = prod_fix[WIDTH-1:0];
            fix_hi  = prod_fix[2*WIDTH-1:WIDTH];
            fix_exc = signed_reg ? (fix_hi != {WIDTH{fix_lo[WIDTH-1]}})
                                 : (fix_hi != '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            hi_reg         <= '0;
            lo_reg         <= '0;
            op_reg         <= '0;
            cnt_reg        <= '0;
            is_div_reg     <= 1'b0;
            signed_reg     <= 1'b0;
            neg_a_reg      <= 1'b0;
            neg_b_reg      <= 1'b0;
            min_ovf_reg    <= 1'b0;
            exc_reg        <= 1'b0;
            data_result    <= '0;
            data_result_hi <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            data_exception <= 1'b0;
            // a new request always wins, silently discarding whatever is in flight
            if (start) begin
                state_reg   <= ctrl_MULT ? S_MUL : S_DIV;
                is_div_reg  <= ~ctrl_MULT;
                signed_reg  <= ctrl_signed;
                neg_a_reg   <= a_neg;
                neg_b_reg   <= b_neg;
                min_ovf_reg <= ~ctrl_MULT & ctrl_signed &
                               (data_operandA == MIN_VAL) & (data_operandB == '1);
                hi_reg      <= '0;
                lo_reg      <= a_mag;
                op_reg      <= b_mag;
                cnt_reg     <= '0;
                busy        <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_MUL: begin
                        hi_reg  <= mul_sum[WIDTH:1];
                        lo_reg  <= {mul_sum[0], lo_reg[WIDTH-1:1]};
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_ITER) state_reg <= S_FIX;
                    end
                    S_DIV: begin
                        if (op_reg == '0) begin
                            hi_reg    <= dividend_raw;
                            lo_reg    <= '0;
                            exc_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            hi_reg  <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            lo_reg  <= {lo_reg[WIDTH-2:0], div_ge};
                            cnt_reg <= cnt_reg + 1'b1;
                            if (cnt_reg == LAST_ITER) state_reg <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        hi_reg    <= fix_hi;
                        lo_reg    <= fix_lo;
                        exc_reg   <= fix_exc;
                        state_reg <= S_DONE;
                    end
                    S_DONE: begin
                        data_result    <= lo_reg;
                        data_result_hi <= hi_reg;
                        data_exception <= exc_reg;
                        data_resultRDY <= 1'b1;
                        state_reg      <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iterative_multdiv_unit.sv
// Bench for iterative_multdiv_unit: directed and random operations against a
// plain-arithmetic reference model, plus abort, restart and mid-operation reset.
module tb_iterative_multdiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  opa, opb;
    logic          cm, cd, cs;
    logic [W-1:0]  data_result, data_result_hi;
    logic          data_exception, data_resultRDY, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iterative_multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clk),
        .reset          (rst),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (cm),
        .ctrl_DIV       (cd),
        .ctrl_signed    (cs),
        .data_result    (data_result),
        .data_result_hi (data_result_hi),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Reference: full-precision integer arithmetic on the operand values.
    task automatic model(input bit is_mul, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi, output logic exc, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p, qv, rv;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (is_mul) begin
            p   = sa * sb;
            lo  = p[31:0];
            hi  = p[63:32];
            exc = sgn ? (longint'(p) != longint'($signed(p[31:0]))) : (p[63:32] != 0);
            lat = W + 2;
        end else if (b == 0) begin
            lo = 0; hi = a; exc = 1'b1; lat = 2;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000; hi = 0; exc = 1'b1; lat = W + 2;
        end else begin
            q = sa / sb; r = sa % sb;
            qv = q; rv = r;
            lo = qv[31:0]; hi = rv[31:0]; exc = 1'b0; lat = W + 2;
        end
    endtask

    task automatic issue(input bit m, input bit d, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        opa = a; opb = b; cm = m; cd = d; cs = s;
        @(posedge clk);
        #1;
        cm = 1'b0; cd = 1'b0;
        opa = $urandom; opb = $urandom; cs = 1'($urandom);
    endtask

    // Drives one request and observes it; comparisons are made by the callers.
    task automatic do_op(input bit m, input bit d, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] lo, output logic [W-1:0] hi, output logic exc,
                         output int lat, output logic [1:0] at_start, output logic [2:0] after);
        lo = 'x; hi = 'x; exc = 1'bx; lat = -1;
        issue(m, d, s, a, b);
        at_start = {data_resultRDY, busy};
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (data_resultRDY) begin
                lat = k; lo = data_result; hi = data_result_hi; exc = data_exception;
                break;
            end
        end
        @(posedge clk);
        #1;
        after = {data_resultRDY, busy, data_exception};
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = 0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 20));
            4: v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; cm = 1'b0; cd = 1'b0; cs = 1'b0; opa = 0; opb = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({data_result, data_result_hi, data_exception, data_resultRDY, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_result_hi, data_exception, data_resultRDY, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({data_resultRDY, busy} !== 2'b00) begin
            bad++;
            $display("FAIL post_reset_idle got rdy=%b busy=%b want 0 0", data_resultRDY, busy);
        end
    endtask

    task automatic test_directed();
        bit          dm[8] = '{1, 1, 0, 0, 0, 0, 1, 0};
        bit          ds[8] = '{0, 1, 1, 0, 1, 0, 1, 1};
        logic [W-1:0] da[8] = '{32'h0001_0000, -32'sd7, -32'sd7, 32'd100, 32'h8000_0000, 32'd10, 32'h8000_0000, -32'sd100};
        logic [W-1:0] db[8] = '{32'h0001_0000, 32'd6, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd0};
        logic [W-1:0] elo, ehi, lo, hi;
        logic eexc, exc;
        int elat, lat;
        logic [1:0] st;
        logic [2:0] af;
        for (int i = 0; i < 8; i++) begin
            model(dm[i], ds[i], da[i], db[i], elo, ehi, eexc, elat);
            do_op(dm[i], !dm[i], ds[i], da[i], db[i], lo, hi, exc, lat, st, af);
            total++;
            if ({hi, lo, exc} !== {ehi, elo, eexc}) begin
                bad++;
                $display("FAIL directed%0d_result got hi=%h lo=%h exc=%b want hi=%h lo=%h exc=%b",
                         i, hi, lo, exc, ehi, elo, eexc);
            end
            total++;
            if (lat !== elat) begin
                bad++;
                $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, elat);
            end
            total++;
            if (st !== 2'b01) begin
                bad++;
                $display("FAIL directed%0d_start got rdy,busy=%b want 01", i, st);
            end
            total++;
            if (af !== 3'b000) begin
                bad++;
                $display("FAIL directed%0d_after got rdy,busy,exc=%b want 000", i, af);
            end
            repeat (3) @(posedge clk);
            #1;
            total++;
            if ({data_result_hi, data_result} !== {ehi, elo}) begin
                bad++;
                $display("FAIL directed%0d_hold got hi=%h lo=%h want hi=%h lo=%h",
                         i, data_result_hi, data_result, ehi, elo);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, elo, ehi, lo, hi;
        logic eexc, exc;
        bit m, d, s;
        int elat, lat;
        logic [1:0] st;
        logic [2:0] af;
        for (int i = 0; i < 60; i++) begin
            a = pick(); b = pick();
            m = 1'($urandom); s = 1'($urandom);
            d = !m || ($urandom_range(0, 3) == 0);
            model(m, s, a, b, elo, ehi, eexc, elat);
            do_op(m, d, s, a, b, lo, hi, exc, lat, st, af);
            total++;
            if ({hi, lo, exc, lat} !== {ehi, elo, eexc, elat}) begin
                bad++;
                $display("FAIL random%0d m=%b d=%b s=%b a=%h b=%h got hi=%h lo=%h exc=%b lat=%0d want hi=%h lo=%h exc=%b lat=%0d",
                         i, m, d, s, a, b, hi, lo, exc, lat, ehi, elo, eexc, elat);
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] lo, hi;
        logic exc;
        int lat;
        logic [1:0] st;
        logic [2:0] af;
        bit early = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 32'd1234, 32'd5678);
        repeat (9) begin
            @(posedge clk); #1;
            if (data_resultRDY) early = 1'b1;
        end
        do_op(1'b0, 1'b1, 1'b0, 32'd10, 32'd3, lo, hi, exc, lat, st, af);
        total++;
        if (early || st !== 2'b01) begin
            bad++;
            $display("FAIL abort_no_rdy got early=%b rdy,busy=%b want 0 01", early, st);
        end
        total++;
        if ({lo, hi, exc, lat} !== {32'd3, 32'd1, 1'b0, W + 2}) begin
            bad++;
            $display("FAIL abort_restart got q=%h r=%h exc=%b lat=%0d want q=3 r=1 exc=0 lat=%0d",
                     lo, hi, exc, lat, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, elo, ehi, lo, hi;
        logic eexc, exc;
        int elat, lat;
        logic [1:0] st;
        logic [2:0] af;
        bit early;
        for (int i = 0; i < 3; i++) begin
            early = 1'b0;
            issue(1'b1, 1'b0, 1'b1, $urandom, $urandom);
            // the next start lands on the edge the aborted multiply would have raised RDY
            repeat (W + 1) begin
                @(posedge clk); #1;
                if (data_resultRDY) early = 1'b1;
            end
            a = pick(); b = pick();
            model(1'b0, 1'b1, a, b, elo, ehi, eexc, elat);
            do_op(1'b0, 1'b1, 1'b1, a, b, lo, hi, exc, lat, st, af);
            total++;
            if (early || st !== 2'b01) begin
                bad++;
                $display("FAIL b2b%0d_abort_in_done got early=%b rdy,busy=%b want 0 01", i, early, st);
            end
            total++;
            if ({hi, lo, exc, lat} !== {ehi, elo, eexc, elat}) begin
                bad++;
                $display("FAIL b2b%0d_result got hi=%h lo=%h exc=%b lat=%0d want hi=%h lo=%h exc=%b lat=%0d",
                         i, hi, lo, exc, lat, ehi, elo, eexc, elat);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        bit busy_seen = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 32'd999, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({data_result, data_result_hi, data_exception, data_resultRDY, busy} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h/%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_result_hi, data_exception, data_resultRDY, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (data_resultRDY) seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        total++;
        if (seen || busy_seen) begin
            bad++;
            $display("FAIL midreset_quiet got rdy_seen=%b busy_seen=%b want 0 0", seen, busy_seen);
        end
    endtask

    task automatic test_recovery();
        logic [W-1:0] lo, hi;
        logic exc;
        int lat;
        logic [1:0] st;
        logic [2:0] af;
        do_op(1'b1, 1'b0, 1'b1, -32'sd7, 32'd6, lo, hi, exc, lat, st, af);
        total++;
        if ({hi, lo, exc, lat} !== {32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, W + 2}) begin
            bad++;
            $display("FAIL recovery_mult got hi=%h lo=%h exc=%b lat=%0d want hi=ffffffff lo=ffffffd6 exc=0 lat=%0d",
                     hi, lo, exc, lat, W + 2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        test_recovery();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
